// File: rtl/loop_dispatch.sv
// loop_dispatch: feeds the instruction queue from the decoder, capturing
// innermost loop bodies and replaying them as replicated pushes.
// Ports: clk/reset (sync, active-high); in_* decoded instruction handshake;
//   iq_* push port to the instruction queue with iq_stall_push backpressure;
//   busy (work in flight) and body_overflow (sticky nesting/size error).
module loop_dispatch #(
   parameter int BODY_DEPTH        = 8,
   parameter int SUPERSCALAR_WIDTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_kind,
   input  logic [1:0]  in_instr_type,
   input  logic [8:0]  in_payload,
   input  logic [10:0] in_cache_addr,
   input  logic [10:0] in_cache_stride,
   input  logic [6:0]  in_mem_addr,
   input  logic [6:0]  in_mem_stride,
   input  logic [15:0] in_loop_count,
   output logic        iq_we,
   output logic [1:0]  iq_instr_type,
   output logic [4:0]  iq_copy_count,
   output logic [10:0] iq_cache_addr,
   output logic [10:0] iq_d_cache_addr,
   output logic [6:0]  iq_main_mem_addr,
   output logic [6:0]  iq_d_main_mem_addr,
   output logic [8:0]  iq_arith_instr,
   output logic [2:0]  iq_ram_instr,
   output logic [6:0]  iq_ld_st_instr,
   input  logic        iq_stall_push,
   output logic        busy,
   output logic        body_overflow
);

   localparam int IW = $clog2(BODY_DEPTH);
   localparam int CW = $clog2(BODY_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(BODY_DEPTH);
   localparam logic [16:0] WIDTH_C = 17'(SUPERSCALAR_WIDTH);

   localparam logic [1:0] K_OP    = 2'd0;
   localparam logic [1:0] K_START = 2'd1;
   localparam logic [1:0] K_END   = 2'd2;

   localparam logic [1:0] T_RAM = 2'd0;
   localparam logic [1:0] T_LS  = 2'd1;
   localparam logic [1:0] T_AR  = 2'd2;

   typedef enum logic [1:0] {
      S_PASS,
      S_CAPTURE,
      S_REPLAY,
      S_ERROR
   } state_t;

   state_t state, state_n;

   logic        pend_valid;
   logic [1:0]  pend_type;
   logic [8:0]  pend_payload;
   logic [4:0]  pend_copy;
   logic [10:0] pend_cache, pend_dcache;
   logic [6:0]  pend_mem, pend_dmem;

   logic [1:0]  b_type    [BODY_DEPTH];
   logic [8:0]  b_payload [BODY_DEPTH];
   logic [10:0] b_cache   [BODY_DEPTH];
   logic [10:0] b_cstride [BODY_DEPTH];
   logic [6:0]  b_mem     [BODY_DEPTH];
   logic [6:0]  b_mstride [BODY_DEPTH];

   logic [CW-1:0] body_cnt;
   logic [IW-1:0] idx;
   logic [15:0]   n_reg;
   logic [16:0]   done;

   logic        free, last;
   logic        take_op, take_rep, append, start, close, ovf_set;
   logic [16:0] remain, done_n;
   logic [4:0]  c;
   logic [10:0] cache_nx;
   logic [6:0]  mem_nx;

   assign iq_we  = pend_valid & ~iq_stall_push;
   assign free   = ~pend_valid | iq_we;
   assign remain = {1'b0, n_reg} - done;
   // copies in this pass: a full superscalar group or whatever is left
   assign c      = (remain >= WIDTH_C) ? 5'(SUPERSCALAR_WIDTH) : remain[4:0];
   assign done_n = done + {12'd0, c};
   assign last   = (CW'(idx) == body_cnt - CW'(1));
   // running addresses wrap naturally at their field widths
   assign cache_nx = b_cache[idx] + b_cstride[idx] * {6'd0, c};
   assign mem_nx   = b_mem[idx] + b_mstride[idx] * {2'd0, c};

   always_comb begin
      state_n  = state;
      in_ready = 1'b0;
      take_op  = 1'b0;
      take_rep = 1'b0;
      append   = 1'b0;
      start    = 1'b0;
      close    = 1'b0;
      ovf_set  = 1'b0;
      unique case (state)
         S_PASS: begin
            in_ready = free;
            if (in_valid && free) begin
               if (in_kind == K_OP) begin
                  take_op = 1'b1;
               end else if (in_kind == K_START) begin
                  start   = 1'b1;
                  state_n = S_CAPTURE;
               end
            end
         end
         S_CAPTURE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               case (in_kind)
                  K_OP: begin
                     if (body_cnt == DEPTH_C) begin
                        ovf_set = 1'b1;
                        state_n = S_ERROR;
                     end else begin
                        append = 1'b1;
                     end
                  end
                  K_START: begin
                     ovf_set = 1'b1;
                     state_n = S_ERROR;
                  end
                  K_END: begin
                     close = 1'b1;
                     if (n_reg != 16'd0 && body_cnt != '0)
                        state_n = S_REPLAY;
                     else
                        state_n = S_PASS;
                  end
                  default: ;
               endcase
            end
         end
         S_REPLAY: begin
            if (free) begin
               take_rep = 1'b1;
               if (last && done_n >= {1'b0, n_reg})
                  state_n = S_PASS;
            end
         end
         S_ERROR: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_PASS;
      else       state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_valid    <= 1'b0;
         pend_type     <= '0;
         pend_payload  <= '0;
         pend_copy     <= '0;
         pend_cache    <= '0;
         pend_dcache   <= '0;
         pend_mem      <= '0;
         pend_dmem     <= '0;
         body_cnt      <= '0;
         idx           <= '0;
         n_reg         <= '0;
         done          <= '0;
         body_overflow <= 1'b0;
      end else begin
         if (take_op) begin
            pend_valid   <= 1'b1;
            pend_type    <= in_instr_type;
            pend_payload <= in_payload;
            pend_copy    <= 5'd1;
            pend_cache   <= in_cache_addr;
            pend_dcache  <= '0;
            pend_mem     <= in_mem_addr;
            pend_dmem    <= '0;
         end else if (take_rep) begin
            pend_valid   <= 1'b1;
            pend_type    <= b_type[idx];
            pend_payload <= b_payload[idx];
            pend_copy    <= c;
            pend_cache   <= b_cache[idx];
            pend_dcache  <= b_cstride[idx];
            pend_mem     <= b_mem[idx];
            pend_dmem    <= b_mstride[idx];
         end else if (iq_we) begin
            pend_valid <= 1'b0;
         end
         if (start) begin
            n_reg    <= in_loop_count;
            body_cnt <= '0;
         end
         if (append) body_cnt <= body_cnt + CW'(1);
         if (close) begin
            done <= '0;
            idx  <= '0;
         end
         if (take_rep) begin
            if (last) begin
               idx  <= '0;
               done <= done_n;
            end else begin
               idx <= idx + IW'(1);
            end
         end
         if (ovf_set) body_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (append && !reset) begin
         b_type[body_cnt[IW-1:0]]    <= in_instr_type;
         b_payload[body_cnt[IW-1:0]] <= in_payload;
         b_cache[body_cnt[IW-1:0]]   <= in_cache_addr;
         b_cstride[body_cnt[IW-1:0]] <= in_cache_stride;
         b_mem[body_cnt[IW-1:0]]     <= in_mem_addr;
         b_mstride[body_cnt[IW-1:0]] <= in_mem_stride;
      end
      if (take_rep && !reset) begin
         b_cache[idx] <= cache_nx;
         b_mem[idx]   <= mem_nx;
      end
   end

   assign iq_instr_type      = pend_type;
   assign iq_copy_count      = pend_copy;
   assign iq_cache_addr      = pend_cache;
   assign iq_d_cache_addr    = pend_dcache;
   assign iq_main_mem_addr   = pend_mem;
   assign iq_d_main_mem_addr = pend_dmem;
   assign iq_arith_instr = (pend_type == T_AR)  ? pend_payload      : '0;
   assign iq_ram_instr   = (pend_type == T_RAM) ? pend_payload[2:0] : '0;
   assign iq_ld_st_instr = (pend_type == T_LS)  ? pend_payload[6:0] : '0;

   assign busy = (state == S_CAPTURE) | (state == S_REPLAY) | pend_valid;

endmodule

// File: tb/tb_loop_dispatch.sv
// tb_loop_dispatch: self-checking bench for loop_dispatch.
// Table of pass-through vectors, directed loop corner cases, random programs.
module tb_loop_dispatch;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_kind, in_instr_type;
   logic [8:0]  in_payload;
   logic [10:0] in_cache_addr, in_cache_stride;
   logic [6:0]  in_mem_addr, in_mem_stride;
   logic [15:0] in_loop_count;
   logic        iq_we;
   logic [1:0]  iq_instr_type;
   logic [4:0]  iq_copy_count;
   logic [10:0] iq_cache_addr, iq_d_cache_addr;
   logic [6:0]  iq_main_mem_addr, iq_d_main_mem_addr;
   logic [8:0]  iq_arith_instr;
   logic [2:0]  iq_ram_instr;
   logic [6:0]  iq_ld_st_instr;
   logic        stall;
   logic        busy, body_overflow;

   always #5 clk = ~clk;

   loop_dispatch dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_kind(in_kind), .in_instr_type(in_instr_type),
      .in_payload(in_payload),
      .in_cache_addr(in_cache_addr), .in_cache_stride(in_cache_stride),
      .in_mem_addr(in_mem_addr), .in_mem_stride(in_mem_stride),
      .in_loop_count(in_loop_count),
      .iq_we(iq_we), .iq_instr_type(iq_instr_type),
      .iq_copy_count(iq_copy_count),
      .iq_cache_addr(iq_cache_addr), .iq_d_cache_addr(iq_d_cache_addr),
      .iq_main_mem_addr(iq_main_mem_addr),
      .iq_d_main_mem_addr(iq_d_main_mem_addr),
      .iq_arith_instr(iq_arith_instr), .iq_ram_instr(iq_ram_instr),
      .iq_ld_st_instr(iq_ld_st_instr),
      .iq_stall_push(stall), .busy(busy), .body_overflow(body_overflow)
   );

   typedef struct packed {
      logic [1:0]  kind, typ;
      logic [8:0]  pl;
      logic [10:0] ca, cs;
      logic [6:0]  ma, ms;
      logic [15:0] n;
   } item_t;

   typedef struct packed {
      logic [1:0]  typ;
      logic [4:0]  copy;
      logic [10:0] ca, dca;
      logic [6:0]  ma, dma;
      logic [8:0]  ar;
      logic [2:0]  rm;
      logic [6:0]  ls;
   } push_t;

   typedef struct {
      logic [1:0]  typ;
      logic [8:0]  pl;
      logic [10:0] ca;
      logic [6:0]  ma;
      logic [8:0]  ar;
      logic [2:0]  rm;
      logic [6:0]  ls;
   } vec_t;

   int    total = 0;
   int    bad   = 0;
   logic  mon_en = 1'b0;
   logic  rand_stall = 1'b0;
   push_t exp_q[$];
   vec_t  tbl[6];

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic push_t mk(logic [1:0] t, logic [8:0] pl,
                                logic [4:0] cp, logic [10:0] ca,
                                logic [10:0] dca, logic [6:0] ma,
                                logic [6:0] dma);
      push_t p;
      p.typ  = t;
      p.copy = cp;
      p.ca   = ca;
      p.dca  = dca;
      p.ma   = ma;
      p.dma  = dma;
      p.ar   = (t == 2'd2) ? pl : 9'd0;
      p.rm   = (t == 2'd0) ? pl[2:0] : 3'd0;
      p.ls   = (t == 2'd1) ? pl[6:0] : 7'd0;
      return p;
   endfunction

   function automatic push_t dut_push();
      push_t p;
      p.typ  = iq_instr_type;
      p.copy = iq_copy_count;
      p.ca   = iq_cache_addr;
      p.dca  = iq_d_cache_addr;
      p.ma   = iq_main_mem_addr;
      p.dma  = iq_d_main_mem_addr;
      p.ar   = iq_arith_instr;
      p.rm   = iq_ram_instr;
      p.ls   = iq_ld_st_instr;
      return p;
   endfunction

   function automatic item_t op(logic [1:0] t, logic [8:0] pl,
                                logic [10:0] ca, logic [10:0] cs,
                                logic [6:0] ma, logic [6:0] ms);
      item_t it;
      it.kind = 2'd0; it.typ = t; it.pl = pl;
      it.ca = ca; it.cs = cs; it.ma = ma; it.ms = ms;
      it.n = 16'd0;
      return it;
   endfunction

   function automatic item_t ctl(logic [1:0] k, logic [15:0] n);
      item_t it;
      it = op(2'(k + 2'd1), 9'(n), 11'(n * 3), 11'd5, 7'(n), 7'd1);
      it.kind = k;
      it.n = n;
      return it;
   endfunction

   function automatic item_t rop();
      return op(2'($urandom_range(0, 3)), 9'($urandom), 11'($urandom),
                11'($urandom), 7'($urandom), 7'($urandom));
   endfunction

   // reference: pass-through OP is one single-copy push at its base address
   task automatic exp_op(input item_t it);
      exp_q.push_back(mk(it.typ, it.pl, 5'd1, it.ca, 11'd0, it.ma, 7'd0));
   endtask

   // reference: passes of up to 16 copies, address = base + stride*done
   task automatic exp_loop(input int n, input item_t body[$]);
      int done = 0;
      int cc;
      while (done < n) begin
         cc = (n - done > 16) ? 16 : n - done;
         foreach (body[e])
            exp_q.push_back(mk(body[e].typ, body[e].pl, 5'(cc),
               11'((int'(body[e].ca) + int'(body[e].cs) * done) % 2048),
               body[e].cs,
               7'((int'(body[e].ma) + int'(body[e].ms) * done) % 128),
               body[e].ms));
         done += cc;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input item_t it);
      int k = 0;
      in_kind = it.kind; in_instr_type = it.typ; in_payload = it.pl;
      in_cache_addr = it.ca; in_cache_stride = it.cs;
      in_mem_addr = it.ma; in_mem_stride = it.ms;
      in_loop_count = it.n;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && k < 10000) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: in_ready stuck low, kind %0d", it.kind);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(string name);
      int k = 0;
      while (exp_q.size() != 0 && k < 20000) begin
         @(negedge clk);
         k++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s_drain: %0d pushes missing, want 0", name,
                  exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
      check({name, "_busy"}, 64'(busy), 64'(0));
      tick();
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (mon_en && iq_we) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL push_extra: got push %0h want none",
                        dut_push());
            end else begin
               check("push", 64'(dut_push()), 64'(exp_q.pop_front()));
            end
         end
      end
   endtask

   task automatic stall_gen();
      forever begin
         @(posedge clk);
         #1;
         if (rand_stall) stall = ($urandom_range(0, 3) == 0);
      end
   endtask

   initial begin
      item_t opa, opb, body[$];
      push_t p[4];
      int nb, nn, sel;

      tbl[0] = '{2'd1, 9'h1AB, 11'd100,  7'd5,   9'h000, 3'd0, 7'h2B};
      tbl[1] = '{2'd2, 9'h1FF, 11'd7,    7'd127, 9'h1FF, 3'd0, 7'h00};
      tbl[2] = '{2'd0, 9'h0F5, 11'd2047, 7'd0,   9'h000, 3'd5, 7'h00};
      tbl[3] = '{2'd3, 9'h1FF, 11'd1,    7'd1,   9'h000, 3'd0, 7'h00};
      tbl[4] = '{2'd1, 9'h080, 11'd0,    7'd64,  9'h000, 3'd0, 7'h00};
      tbl[5] = '{2'd2, 9'h000, 11'd1024, 7'd3,   9'h000, 3'd0, 7'h00};

      reset = 1'b1; in_valid = 1'b0; stall = 1'b0;
      in_kind = '0; in_instr_type = '0; in_payload = '0;
      in_cache_addr = '0; in_cache_stride = '0;
      in_mem_addr = '0; in_mem_stride = '0; in_loop_count = '0;
      fork
         monitor();
         stall_gen();
      join_none
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst_we", 64'(iq_we), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_ovf", 64'(body_overflow), 64'(0));
      check("rst_ready", 64'(in_ready), 64'(1));
      check("rst_out", 64'(dut_push()), 64'(0));
      tick();

      // pass-through table, one push the cycle after acceptance
      for (int i = 0; i < 6; i++) begin
         push_t e;
         send(op(tbl[i].typ, tbl[i].pl, tbl[i].ca, 11'd9,
                 tbl[i].ma, 7'd9));
         @(negedge clk);
         e.typ = tbl[i].typ; e.copy = 5'd1;
         e.ca = tbl[i].ca; e.dca = 11'd0;
         e.ma = tbl[i].ma; e.dma = 7'd0;
         e.ar = tbl[i].ar; e.rm = tbl[i].rm; e.ls = tbl[i].ls;
         check("pt_we", 64'(iq_we), 64'(1));
         check("pt_push", 64'(dut_push()), 64'(e));
         tick();
      end

      // N=20, body {LS cache 0 stride 4, ARITH}
      opa = op(2'd1, 9'h0C3, 11'd0, 11'd4, 7'd10, 7'd2);
      opb = op(2'd2, 9'h155, 11'd500, 11'd0, 7'd0, 7'd0);
      p[0] = mk(2'd1, 9'h0C3, 5'd16, 11'd0,   11'd4, 7'd10, 7'd2);
      p[1] = mk(2'd2, 9'h155, 5'd16, 11'd500, 11'd0, 7'd0,  7'd0);
      p[2] = mk(2'd1, 9'h0C3, 5'd4,  11'd64,  11'd4, 7'd42, 7'd2);
      p[3] = mk(2'd2, 9'h155, 5'd4,  11'd500, 11'd0, 7'd0,  7'd0);
      mon_en = 1'b1;
      foreach (p[i]) exp_q.push_back(p[i]);
      send(ctl(2'd1, 16'd20));
      send(opa);
      send(opb);
      send(ctl(2'd2, 16'd0));
      @(negedge clk);
      check("rep_lat1", 64'(iq_we), 64'(0));
      @(negedge clk);
      check("rep_lat2", 64'(iq_we), 64'(1));
      wait_drain("n20");

      // same loop with a 5-cycle stall on the second push
      foreach (p[i]) exp_q.push_back(p[i]);
      send(ctl(2'd1, 16'd20));
      send(opa);
      send(opb);
      send(ctl(2'd2, 16'd0));
      @(negedge clk);
      @(negedge clk);
      tick();
      stall = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("stall_we", 64'(iq_we), 64'(0));
         check("stall_hold", 64'(dut_push()), 64'(p[1]));
         check("stall_ready", 64'(in_ready), 64'(0));
      end
      tick();
      stall = 1'b0;
      wait_drain("stall");

      // N=0 with one body entry
      send(ctl(2'd1, 16'd0));
      send(opa);
      send(ctl(2'd2, 16'd0));
      @(negedge clk);
      check("n0_ready", 64'(in_ready), 64'(1));
      check("n0_busy", 64'(busy), 64'(0));
      repeat (4) tick();

      // address wrap on the second pass
      exp_q.push_back(mk(2'd0, 9'h007, 5'd16, 11'd2040, 11'd8, 7'd120, 7'd1));
      exp_q.push_back(mk(2'd0, 9'h007, 5'd16, 11'd120,  11'd8, 7'd8,   7'd1));
      send(ctl(2'd1, 16'd32));
      send(op(2'd0, 9'h007, 11'd2040, 11'd8, 7'd120, 7'd1));
      send(ctl(2'd2, 16'd0));
      wait_drain("wrap");

      // maximum iteration count
      body.delete();
      body.push_back(op(2'd1, 9'h011, 11'd3, 11'd5, 7'd1, 7'd3));
      exp_loop(65535, body);
      send(ctl(2'd1, 16'd65535));
      send(body[0]);
      send(ctl(2'd2, 16'd0));
      wait_drain("nmax");

      // reset in the middle of a replay
      mon_en = 1'b0;
      send(ctl(2'd1, 16'd64));
      send(opa);
      send(opb);
      send(ctl(2'd2, 16'd0));
      repeat (3) tick();
      reset = 1'b1;
      @(negedge clk);
      check("pre_rst_we", 64'(iq_we), 64'(1));
      @(negedge clk);
      check("mid_rst_we", 64'(iq_we), 64'(0));
      check("mid_rst_busy", 64'(busy), 64'(0));
      tick();
      reset = 1'b0;
      tick();
      mon_en = 1'b1;

      // body overflow: 9 OPs after LOOP_START
      send(ctl(2'd1, 16'd5));
      repeat (9) send(opa);
      @(negedge clk);
      check("ovf_flag", 64'(body_overflow), 64'(1));
      check("ovf_ready", 64'(in_ready), 64'(0));
      tick();
      in_kind = 2'd0;
      in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("err_ready", 64'(in_ready), 64'(0));
      end
      tick();
      in_valid = 1'b0;
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      @(negedge clk);
      check("ovf_clr", 64'(body_overflow), 64'(0));
      tick();
      exp_op(opb);
      send(opb);
      wait_drain("post_ovf");

      // random programs under random backpressure
      rand_stall = 1'b1;
      for (int r = 0; r < 40; r++) begin
         sel = $urandom_range(0, 9);
         if (sel < 6) begin
            opa = rop();
            exp_op(opa);
            send(opa);
         end else if (sel == 6) begin
            send(ctl(2'($urandom_range(2, 3)), 16'($urandom)));
         end else begin
            nb = $urandom_range(0, 8);
            nn = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 70);
            body.delete();
            for (int e = 0; e < nb; e++) body.push_back(rop());
            exp_loop(nn, body);
            send(ctl(2'd1, 16'(nn)));
            foreach (body[e]) begin
               if ($urandom_range(0, 4) == 0)
                  send(ctl(2'd3, 16'd0));
               send(body[e]);
            end
            send(ctl(2'd2, 16'd0));
         end
         repeat ($urandom_range(0, 2)) tick();
      end
      rand_stall = 1'b0;
      tick();
      stall = 1'b0;
      wait_drain("rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/loop_dispatch.md
# loop_dispatch

Upstream feeder of the superscalar instruction queue. Accepts a decoded instruction stream, captures innermost loop bodies into a small body buffer, and replays them as replicated pushes (copy_count up to 16 per push, base address plus per-copy stride) into the queue's push port. Straight-line instructions pass through with copy_count 1. The block sits between the decoder and the instruction queue and honours the queue's stall_push backpressure.

## Interface
- BODY_DEPTH, 8: maximum loop body entries.
- SUPERSCALAR_WIDTH, 16: maximum copies per push.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid / in_ready  in/out  1/1  decoded-instruction handshake; transfer when both are high.
- in_kind  in  2  0=OP, 1=LOOP_START, 2=LOOP_END, 3=reserved (accepted, ignored).
- in_instr_type  in  2  RAM / LOAD_STORE / ARITHMETIC code of an OP.
- in_payload  in  9  opcode bits; arith uses [0:8], ram uses [0:2], ld_st uses [0:6].
- in_cache_addr, in_cache_stride  in  11/11  base cache address and per-iteration stride.
- in_mem_addr, in_mem_stride  in  7/7  base main-memory address and per-iteration stride.
- in_loop_count  in  16  iteration count N; sampled on LOOP_START.
- iq_we  out  1  push strobe.
- iq_instr_type  out  2; iq_copy_count  out  5; iq_cache_addr, iq_d_cache_addr  out  11/11; iq_main_mem_addr, iq_d_main_mem_addr  out  7/7; iq_arith_instr  out  9; iq_ram_instr  out  3; iq_ld_st_instr  out  7.
- iq_stall_push  in  1  queue backpressure.
- busy  out  1  high in CAPTURE/REPLAY or while a push is pending.
- body_overflow  out  1  sticky error flag.

## Operation
- One-entry output register (pend). iq_we = pend_valid & !iq_stall_push. A push completes in any cycle with iq_we=1; pend clears or reloads that cycle.
- States: PASS, CAPTURE, REPLAY, ERROR.
- PASS: in_ready = !pend_valid | iq_we. OP loads pend with copy_count=1, addresses = base, d_* = 0. LOOP_START latches N, clears the body count, and moves to CAPTURE. LOOP_END is ignored.
- CAPTURE: in_ready=1, with no pushes. OP appends {type, payload, cache_addr, cache_stride, mem_addr, mem_stride} to the body. LOOP_END sets done=0. It then goes to REPLAY if N>0 and body count>0, otherwise to PASS. LOOP_START (nesting) or a (BODY_DEPTH+1)th OP sets body_overflow and moves to ERROR.
- REPLAY: in_ready=0. Pass copy count c = min(16, N-done). Entries are loaded into pend in capture order, one per free pend slot. Fields: copy_count=c, cache_addr/main_mem_addr = the entry's running address, d_cache_addr/d_main_mem_addr = the entry's strides.
- After an entry is loaded, its running address is incremented by c*stride, modulo 2^11 (cache) and 2^7 (mem).
- After the last entry of a pass: done += c. If done >= N, go to PASS; otherwise start the next pass at entry 0.
- The payload is routed to the iq_* field matching its type. The other opcode fields are driven 0.
- ERROR: in_ready=0, no pushes. Leaves only on reset. A push already pending still completes.

## Timing
- Reset values: iq_we=0, all iq_* data outputs 0, busy=0, body_overflow=0, state PASS, pend_valid=0, body emptied.
- Pass-through latency: an OP accepted in cycle t can push in cycle t+1.
- Replay without stall: one push per cycle. The first push comes 2 cycles after LOOP_END is accepted. A loop costs ceil(N/16)*B push cycles.
- While iq_stall_push is high, pend holds all fields stable and no new entry is loaded.
- N=0 or an empty body: no pushes, back in PASS the cycle after LOOP_END.
- N=65535 must work: done is 17 bits wide, so it does not overflow.
- Reset mid-CAPTURE or mid-REPLAY: the body, pend and counters are discarded in the same cycle, and no push occurs on the next cycle.

## Test plan
- PASS: LOAD_STORE OP, cache_addr 100 -> one push next cycle: copy_count 1, cache_addr 100, d_cache_addr 0.
- Loop N=20, body {LOAD_STORE cache 0 stride 4, ARITH} -> four pushes: (LS,16,0,4), (AR,16), (LS,4,64,4), (AR,4). The block then returns to PASS.
- Loop N=0 with one body entry -> zero pushes; in_ready high again 1 cycle after LOOP_END.
- iq_stall_push held 5 cycles during the 2nd push of the N=20 case -> iq_we low and outputs frozen during the stall; push sequence identical after release.
- Wrap: RAM entry cache_addr 2040 stride 8, mem_addr 120 stride 1, N=32 -> pass 2 pushes cache_addr 120 and main_mem_addr 8.
- Overflow: LOOP_START followed by 9 OPs -> body_overflow=1, in_ready=0 and no pushes until reset. Reset then clears body_overflow and the block accepts a PASS OP normally.
